// File: rtl/ysyx_24090010_wb_arb_pkg.sv
// Shared constants for the NPC write-back path: data/register geometry and
// the requester indices used by the write-port arbiter.
package ysyx_24090010_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned NREG   = 32;
  localparam int unsigned REG_AW = $clog2(NREG);

  localparam int unsigned WB_EX = 0;
  localparam int unsigned WB_LS = 1;

endpackage

// File: rtl/ysyx_24090010_wb_arb_if.sv
// Bundle of EXU/LSU write requests, decoder issue fields and the registered
// register-file write port seen by the write-back arbiter.
interface ysyx_24090010_wb_arb_if #(
  parameter int unsigned XLEN = ysyx_24090010_pkg::XLEN,
  parameter int unsigned NREG = ysyx_24090010_pkg::NREG
);
  localparam int unsigned AW = $clog2(NREG);

  logic            ex_valid;
  logic [AW-1:0]   ex_rd;
  logic [XLEN-1:0] ex_data;
  logic            ex_ready;

  logic            ls_valid;
  logic [AW-1:0]   ls_rd;
  logic [XLEN-1:0] ls_data;
  logic            ls_ready;

  logic            issue_valid;
  logic            issue_rd_en;
  logic [AW-1:0]   issue_rd;
  logic [AW-1:0]   issue_rs1;
  logic [AW-1:0]   issue_rs2;
  logic            issue_ready;
  logic            stall;
  logic            flush;

  logic            reg_wen;
  logic [AW-1:0]   rd;
  logic [XLEN-1:0] write_reg_data;

  modport slave (
    input  ex_valid, ex_rd, ex_data,
    output ex_ready,
    input  ls_valid, ls_rd, ls_data,
    output ls_ready,
    input  issue_valid, issue_rd_en, issue_rd, issue_rs1, issue_rs2, flush,
    output issue_ready, stall,
    output reg_wen, rd, write_reg_data
  );

  modport master (
    output ex_valid, ex_rd, ex_data,
    input  ex_ready,
    output ls_valid, ls_rd, ls_data,
    input  ls_ready,
    output issue_valid, issue_rd_en, issue_rd, issue_rs1, issue_rs2, flush,
    input  issue_ready, stall,
    input  reg_wen, rd, write_reg_data
  );

endinterface

// File: rtl/ysyx_24090010_rr_arb2.sv
// Two-way round-robin arbiter; grants are combinational, last winner is held
// in a flop that resets to LS so EX wins the first tie.
module ysyx_24090010_rr_arb2
  import ysyx_24090010_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic last_gnt_q;
  logic last_gnt_d;
  logic win;

  always_comb begin
    gnt = '0;
    win = last_gnt_q;
    if (req[WB_EX] && req[WB_LS]) begin
      win = ~last_gnt_q;  // tie goes to whoever was not served last
    end else if (req[WB_EX]) begin
      win = 1'(WB_EX);
    end else if (req[WB_LS]) begin
      win = 1'(WB_LS);
    end
    gnt[win]   = |req;
    last_gnt_d = (|req) ? win : last_gnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt_q <= 1'(WB_LS);
    end else begin
      last_gnt_q <= last_gnt_d;
    end
  end

endmodule

// File: rtl/ysyx_24090010_wb_arb.sv
// Write-back arbiter: shares the register-file write port between EXU and LSU
// and keeps the busy scoreboard that stalls issue on RAW/WAW hazards.
module ysyx_24090010_wb_arb
  import ysyx_24090010_pkg::*;
#(
  parameter int unsigned XLEN = ysyx_24090010_pkg::XLEN,
  parameter int unsigned NREG = ysyx_24090010_pkg::NREG
) (
  input logic                  clk,
  input logic                  rst,
  ysyx_24090010_wb_arb_if.slave bus
);

  localparam int unsigned AW = $clog2(NREG);

  logic [1:0]      req;
  logic [1:0]      gnt;
  logic            fire;
  logic [AW-1:0]   win_rd;
  logic [XLEN-1:0] win_data;

  logic            reg_wen_q, reg_wen_d;
  logic [AW-1:0]   rd_q, rd_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [NREG-1:0] busy_q, busy_d;

  logic            stall;
  logic            issue_ready;
  logic            issue_set;

  assign req[WB_EX] = bus.ex_valid;
  assign req[WB_LS] = bus.ls_valid;

  ysyx_24090010_rr_arb2 u_rr_arb2 (
    .clk (clk),
    .rst (rst),
    .req (req),
    .gnt (gnt)
  );

  assign bus.ex_ready = gnt[WB_EX];
  assign bus.ls_ready = gnt[WB_LS];

  always_comb begin
    fire     = |gnt;
    win_rd   = gnt[WB_LS] ? bus.ls_rd   : bus.ex_rd;
    win_data = gnt[WB_LS] ? bus.ls_data : bus.ex_data;
  end

  // Writes to x0 are accepted from the requester but never reach the file.
  always_comb begin
    reg_wen_d = fire && (win_rd != '0);
    rd_d      = fire ? win_rd   : rd_q;
    wdata_d   = fire ? win_data : wdata_q;
  end

  always_comb begin
    stall = bus.issue_valid &&
            (busy_q[bus.issue_rs1] || busy_q[bus.issue_rs2] ||
             (bus.issue_rd_en && busy_q[bus.issue_rd]));
    issue_ready = !stall && !bus.flush;
    issue_set   = bus.issue_valid && issue_ready && bus.issue_rd_en &&
                  (bus.issue_rd != '0);
  end

  assign bus.stall       = stall;
  assign bus.issue_ready = issue_ready;

  // Clear follows the registered write so the file has captured the data;
  // the WAW stall keeps a same-cycle set off the cleared index.
  always_comb begin
    busy_d = busy_q;
    if (reg_wen_q) begin
      busy_d[rd_q] = 1'b0;
    end
    if (issue_set) begin
      busy_d[bus.issue_rd] = 1'b1;
    end
    if (bus.flush) begin
      busy_d = '0;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      reg_wen_q <= 1'b0;
      rd_q      <= '0;
      wdata_q   <= '0;
      busy_q    <= '0;
    end else begin
      reg_wen_q <= reg_wen_d;
      rd_q      <= rd_d;
      wdata_q   <= wdata_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.reg_wen        = reg_wen_q;
  assign bus.rd             = rd_q;
  assign bus.write_reg_data = wdata_q;

endmodule

// File: tb/tb_ysyx_24090010_wb_arb.sv
// Self-checking bench for the write-back arbiter: directed scenarios followed
// by randomized traffic against a queue/array based reference model.
module tb_ysyx_24090010_wb_arb;
  import ysyx_24090010_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ysyx_24090010_wb_arb_if #(.XLEN(XLEN), .NREG(NREG)) bus ();

  ysyx_24090010_wb_arb #(.XLEN(XLEN), .NREG(NREG)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  bit          busy_m [NREG];
  int          last_m = WB_LS;
  bit          wen_m;
  int          rd_m;
  logic [31:0] data_m;
  int          win_g;
  bit          issue_fire_g;

  logic [4:0]  pend [$];
  bit          quiet;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [NREG-1:0] busy_vec();
    logic [NREG-1:0] v;
    for (int i = 0; i < NREG; i++) v[i] = busy_m[i];
    return v;
  endfunction

  task automatic idle_inputs();
    bus.ex_valid = 0; bus.ex_rd = '0; bus.ex_data = '0;
    bus.ls_valid = 0; bus.ls_rd = '0; bus.ls_data = '0;
    bus.issue_valid = 0; bus.issue_rd_en = 0;
    bus.issue_rd = '0; bus.issue_rs1 = '0; bus.issue_rs2 = '0;
    bus.flush = 0;
  endtask

  task automatic set_issue(input bit v, input bit en, input int rd, input int rs1, input int rs2);
    bus.issue_valid = v; bus.issue_rd_en = en;
    bus.issue_rd = 5'(rd); bus.issue_rs1 = 5'(rs1); bus.issue_rs2 = 5'(rs2);
  endtask

  // Called just after a negedge with inputs driven; returns at the next negedge.
  task automatic tick();
    int win;
    bit stall_e, iready_e, ifire;
    #1;
    win = -1;
    if (bus.ex_valid && bus.ls_valid) win = (last_m == int'(WB_EX)) ? int'(WB_LS) : int'(WB_EX);
    else if (bus.ex_valid) win = int'(WB_EX);
    else if (bus.ls_valid) win = int'(WB_LS);
    stall_e = bus.issue_valid && (busy_m[bus.issue_rs1] || busy_m[bus.issue_rs2] ||
              (bus.issue_rd_en && busy_m[bus.issue_rd]));
    iready_e = !stall_e && !bus.flush;
    ifire = bus.issue_valid && iready_e && bus.issue_rd_en && (bus.issue_rd != 0);
    if (!rst) begin
      chk("ex_ready", bus.ex_ready, win == int'(WB_EX));
      chk("ls_ready", bus.ls_ready, win == int'(WB_LS));
      chk("stall", bus.stall, stall_e);
      chk("issue_ready", bus.issue_ready, iready_e);
      chk("set_clear_same_idx", bus.reg_wen && bus.issue_valid && bus.issue_ready &&
          bus.issue_rd_en && (bus.issue_rd != 0) && (bus.issue_rd == bus.rd), 1'b0);
    end
    if (rst) begin
      foreach (busy_m[i]) busy_m[i] = 0;
      last_m = WB_LS; wen_m = 0; rd_m = 0; data_m = '0;
    end else begin
      if (wen_m) busy_m[rd_m] = 0;
      if (ifire) busy_m[bus.issue_rd] = 1;
      if (bus.flush) foreach (busy_m[i]) busy_m[i] = 0;
      wen_m = 0;
      if (win >= 0) begin
        last_m = win;
        rd_m   = (win == int'(WB_LS)) ? int'(bus.ls_rd) : int'(bus.ex_rd);
        data_m = (win == int'(WB_LS)) ? bus.ls_data : bus.ex_data;
        wen_m  = (rd_m != 0);
      end
    end
    win_g = rst ? -1 : win;
    issue_fire_g = ifire && !rst;
    @(posedge clk);
    #1;
    chk("reg_wen", bus.reg_wen, wen_m);
    chk("rd", bus.rd, rd_m);
    chk("write_reg_data", bus.write_reg_data, data_m);
    chk("busy", dut.busy_q, busy_vec());
    @(negedge clk);
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    @(negedge clk);
    tick();
    tick();
    rst = 0;

    // reset values
    #1;
    chk("rst_reg_wen", bus.reg_wen, 1'b0);
    chk("rst_rd", bus.rd, 0);
    chk("rst_wdata", bus.write_reg_data, 0);
    chk("rst_busy", dut.busy_q, 0);
    chk("rst_stall", bus.stall, 1'b0);
    chk("rst_ex_ready", bus.ex_ready, 1'b0);
    chk("rst_ls_ready", bus.ls_ready, 1'b0);
    chk("rst_issue_ready", bus.issue_ready, 1'b1);

    // continuous contention: EX, LS, EX, LS
    bus.ex_valid = 1; bus.ex_rd = 5'd1; bus.ex_data = 32'h1111_0000;
    bus.ls_valid = 1; bus.ls_rd = 5'd2; bus.ls_data = 32'h2222_0000;
    for (int i = 0; i < 4; i++) begin
      #1 chk("tie_ex_gnt", bus.ex_ready, (i % 2) == 0);
      tick();
      if (win_g == int'(WB_EX)) bus.ex_data = $urandom;
      else bus.ls_data = $urandom;
    end
    idle_inputs();

    // LS alone writing x0
    bus.ls_valid = 1; bus.ls_rd = '0; bus.ls_data = 32'hdead;
    #1 chk("x0_ls_ready", bus.ls_ready, 1'b1);
    tick();
    chk("x0_no_wen", bus.reg_wen, 1'b0);
    idle_inputs();

    // RAW on rd=5 resolved by an EX write
    set_issue(1, 1, 5, 0, 0);
    tick();
    chk("raw_busy5", dut.busy_q[5], 1'b1);
    set_issue(1, 0, 0, 5, 0);
    bus.ex_valid = 1; bus.ex_rd = 5'd5; bus.ex_data = 32'h1234;
    #1 chk("raw_stall_n", bus.stall, 1'b1);
    tick();
    bus.ex_valid = 0;
    chk("raw_wen_n1", bus.reg_wen, 1'b1);
    chk("raw_rd_n1", bus.rd, 5);
    chk("raw_data_n1", bus.write_reg_data, 32'h1234);
    #1 chk("raw_stall_n1", bus.stall, 1'b1);
    tick();
    #1 chk("raw_stall_n2", bus.stall, 1'b0);
    tick();
    idle_inputs();

    // WAW on rd=7
    set_issue(1, 1, 7, 0, 0);
    tick();
    #1 chk("waw_stall", bus.stall, 1'b1);
    chk("waw_issue_ready", bus.issue_ready, 1'b0);
    tick();
    chk("waw_busy7", dut.busy_q[7], 1'b1);
    idle_inputs();

    // flush with same-cycle issue and an in-flight write to rd=9
    set_issue(1, 1, 3, 0, 0); tick();
    set_issue(1, 1, 9, 0, 0); tick();
    set_issue(1, 1, 4, 0, 0);
    bus.flush = 1;
    bus.ex_valid = 1; bus.ex_rd = 5'd9; bus.ex_data = 32'h99;
    #1 chk("flush_issue_ready", bus.issue_ready, 1'b0);
    tick();
    idle_inputs();
    chk("flush_busy_clear", dut.busy_q, 0);
    chk("flush_wen9", bus.reg_wen, 1'b1);
    chk("flush_rd9", bus.rd, 9);
    tick();

    // reset in the middle of traffic
    set_issue(1, 1, 6, 0, 0); tick();
    set_issue(0, 0, 0, 0, 0);
    bus.ex_valid = 1; bus.ex_rd = 5'd6; bus.ex_data = 32'h6666;
    rst = 1;
    tick();
    rst = 0;
    idle_inputs();
    chk("mid_rst_wen", bus.reg_wen, 1'b0);
    chk("mid_rst_rd", bus.rd, 0);
    chk("mid_rst_data", bus.write_reg_data, 0);
    chk("mid_rst_busy", dut.busy_q, 0);
    bus.ex_valid = 1; bus.ex_rd = 5'd8; bus.ex_data = 32'h8;
    bus.ls_valid = 1; bus.ls_rd = 5'd10; bus.ls_data = 32'ha;
    #1 chk("mid_rst_tie_ex", bus.ex_ready, 1'b1);
    tick();
    idle_inputs();
    tick();

    // randomized traffic with reservations feeding the requesters
    quiet = 0;
    for (int c = 0; c < 3000; c++) begin
      if (quiet && !bus.ex_valid && !bus.ls_valid && !wen_m) quiet = 0;
      bus.issue_valid = 0;
      bus.flush = 0;
      if (!quiet) begin
        if (!bus.ex_valid && $urandom_range(0, 2) == 0) begin
          if (pend.size() > 0) begin
            bus.ex_rd = pend.pop_front(); bus.ex_data = $urandom; bus.ex_valid = 1;
          end else if ($urandom_range(0, 7) == 0) begin
            bus.ex_rd = '0; bus.ex_data = $urandom; bus.ex_valid = 1;
          end
        end
        if (!bus.ls_valid && $urandom_range(0, 2) == 0) begin
          if (pend.size() > 0) begin
            bus.ls_rd = pend.pop_front(); bus.ls_data = $urandom; bus.ls_valid = 1;
          end else if ($urandom_range(0, 7) == 0) begin
            bus.ls_rd = '0; bus.ls_data = $urandom; bus.ls_valid = 1;
          end
        end
        set_issue($urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
        if ($urandom_range(0, 39) == 0) begin
          bus.flush = 1;
          quiet = 1;
          pend.delete();
        end
      end
      tick();
      if (win_g == int'(WB_EX)) bus.ex_valid = 0;
      if (win_g == int'(WB_LS)) bus.ls_valid = 0;
      if (issue_fire_g) pend.push_back(bus.issue_rd);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
